// File: rtl/rom_cache_assoc.sv
// rom_cache_assoc: set-associative instruction ROM cache with line refill, round-robin replacement and flush sweep
module rom_cache_assoc #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int INDEX_W    = 6,
    parameter int WAYS       = 2,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              cpu_req_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    output logic              cpu_rvalid_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    input  logic              invalidate_i,
    output logic              busy_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ready_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);
    localparam int SETS  = 2 ** INDEX_W;
    localparam int WO    = $clog2(LINE_WORDS);
    localparam int WSW   = WO > 0 ? WO : 1;
    localparam int WW    = WAYS > 1 ? $clog2(WAYS) : 1;
    localparam int TAG_W = ADDR_W - INDEX_W - WO - 2;
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, FILL = 2'd2, FLUSH = 2'd3;

    logic [1:0]         state_q, state_d;
    logic               pend_q, pend_d;
    logic [TAG_W-1:0]   ctag_q, ctag_d;
    logic [INDEX_W-1:0] cidx_q, cidx_d, fidx_q, fidx_d;
    logic [WW-1:0]      vic_q, vic_d;
    logic [WSW-1:0]     cnt_q, cnt_d;
    logic [WAYS-1:0]    valid_q [SETS];
    logic [WW-1:0]      ptr_q [SETS];
    logic [TAG_W-1:0]   tags_q [WAYS][SETS];
    logic [DATA_W-1:0]  data_q [WAYS][SETS][LINE_WORDS];

    logic [TAG_W-1:0]   a_tag;
    logic [INDEX_W-1:0] a_idx;
    logic [WSW-1:0]     a_wsel;
    logic [WAYS-1:0]    way_hit;
    logic [DATA_W-1:0]  hit_data;
    logic [WW-1:0]      vic_sel;
    logic               idle, miss, use_ptr, last_beat;

    assign a_tag  = TAG_W'(cpu_addr_i >> (WO + INDEX_W + 2));
    assign a_idx  = INDEX_W'(cpu_addr_i >> (WO + 2));
    assign a_wsel = WO > 0 ? WSW'(cpu_addr_i >> 2) : '0;

    // victim defaults to the pointer; the downward scan leaves the lowest invalid way
    always_comb begin
        way_hit  = '0;
        hit_data = '0;
        vic_sel  = ptr_q[a_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            way_hit[w] = valid_q[a_idx][w] && (tags_q[w][a_idx] == a_tag);
            hit_data   = hit_data | (way_hit[w] ? data_q[w][a_idx][a_wsel] : '0);
            vic_sel    = valid_q[a_idx][w] ? vic_sel : WW'(w);
        end
    end

    assign idle         = state_q == IDLE;
    assign cpu_rvalid_o = idle & cpu_req_i & (|way_hit);
    assign cpu_rdata_o  = hit_data;
    assign miss         = idle & cpu_req_i & ~(|way_hit) & ~invalidate_i;
    assign use_ptr      = &valid_q[a_idx];
    assign last_beat    = (state_q == FILL) & mem_rvalid_i & (cnt_q == WSW'(LINE_WORDS - 1));
    assign mem_req_o    = state_q == REQ;
    assign mem_addr_o   = {ctag_q, cidx_q, {(WO + 2){1'b0}}};
    assign busy_o       = ~idle | pend_q;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        ctag_d  = ctag_q;
        cidx_d  = cidx_q;
        vic_d   = vic_q;
        cnt_d   = cnt_q;
        fidx_d  = fidx_q;
        case (state_q)
            IDLE: begin
                if (invalidate_i) begin
                    state_d = FLUSH;
                    fidx_d  = '0;
                end else if (miss) begin
                    state_d = REQ;
                    ctag_d  = a_tag;
                    cidx_d  = a_idx;
                    vic_d   = vic_sel;
                end
            end
            REQ: begin
                pend_d  = pend_q | invalidate_i;
                state_d = mem_ready_i ? FILL : REQ;
                cnt_d   = '0;
            end
            FILL: begin
                pend_d = pend_q | invalidate_i;
                cnt_d  = cnt_q + WSW'(mem_rvalid_i);
                if (last_beat) begin
                    state_d = (pend_q | invalidate_i) ? FLUSH : IDLE;
                    pend_d  = 1'b0;
                    fidx_d  = '0;
                end
            end
            default: begin
                fidx_d  = fidx_q + INDEX_W'(1);
                state_d = (&fidx_q) ? IDLE : FLUSH;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            if (miss) begin
                valid_q[a_idx][vic_sel] <= 1'b0;
                if (use_ptr)
                    ptr_q[a_idx] <= (ptr_q[a_idx] == WW'(WAYS - 1)) ? '0 : ptr_q[a_idx] + WW'(1);
            end
            if (last_beat)
                valid_q[cidx_q][vic_q] <= 1'b1;
            if (state_q == FLUSH)
                valid_q[fidx_q] <= '0;
        end
    end

    always_ff @(posedge clk_i) begin
        ctag_q <= ctag_d;
        cidx_q <= cidx_d;
        vic_q  <= vic_d;
        cnt_q  <= cnt_d;
        fidx_q <= fidx_d;
        if (state_q == FILL && mem_rvalid_i)
            data_q[vic_q][cidx_q][cnt_q] <= mem_rdata_i;
        if (last_beat)
            tags_q[vic_q][cidx_q] <= ctag_q;
    end
endmodule

// File: tb/tb_rom_cache_assoc.sv
// tb_rom_cache_assoc: directed checks of lookup, refill, replacement, flush and reset abort
module tb_rom_cache_assoc;
    logic        clk = 1'b0;
    logic        reset, cpu_req, invalidate, mem_ready, mem_rvalid;
    logic [31:0] cpu_addr, mem_rdata;
    logic        cpu_rvalid, busy, mem_req;
    logic [31:0] cpu_rdata, mem_addr;
    int          n_pass = 0, n_total = 0, n;

    rom_cache_assoc dut (
        .clk_i(clk), .reset_i(reset), .cpu_req_i(cpu_req), .cpu_addr_i(cpu_addr),
        .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata), .invalidate_i(invalidate),
        .busy_o(busy), .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_ready_i(mem_ready),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // request probe that never lets the request reach a clock edge, so a miss starts no refill
    task automatic probe(input string tag, input logic [31:0] a, input logic hit, input logic [31:0] d);
        tick();
        cpu_req  = 1'b1;
        cpu_addr = a;
        #1;
        chk({tag, "_rvalid"}, {31'd0, cpu_rvalid}, {31'd0, hit});
        if (hit) chk({tag, "_rdata"}, cpu_rdata, d);
        cpu_req = 1'b0;
    endtask

    task automatic fill(input string tag, input logic [31:0] a, input logic [31:0] base,
                        input int stall, input int gap, input int inv_beat);
        cpu_req  = 1'b1;
        cpu_addr = a;
        #1;
        chk({tag, "_miss"}, {31'd0, cpu_rvalid}, 32'd0);
        tick();
        chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd1);
        chk({tag, "_mem_addr"}, mem_addr, a & 32'hFFFF_FFF0);
        for (int s = 0; s < stall; s++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hDEAD_BEEF;
            tick();
            mem_rvalid = 1'b0;
            chk({tag, "_stall_req"}, {31'd0, mem_req}, 32'd1);
            chk({tag, "_stall_addr"}, mem_addr, a & 32'hFFFF_FFF0);
            chk({tag, "_stall_busy"}, {31'd0, busy}, 32'd1);
            chk({tag, "_stall_rvalid"}, {31'd0, cpu_rvalid}, 32'd0);
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = base + i;
            invalidate = (i == inv_beat);
            tick();
            mem_rvalid = 1'b0;
            invalidate = 1'b0;
            for (int g = 0; g < gap; g++) tick();
        end
        cpu_req = 1'b0;
    endtask

    task automatic count_busy(input string tag);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        chk(tag, n, 64);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; cpu_req = 1'b0; cpu_addr = 32'h0; invalidate = 1'b0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        tick();
        tick();
        cpu_req  = 1'b1;
        cpu_addr = 32'h100;
        #1;
        chk("rst_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        cpu_req = 1'b0;
        reset   = 1'b0;

        fill("cold", 32'h100, 32'hA0, 0, 0, -1);
        probe("cold0", 32'h100, 1'b1, 32'hA0);
        probe("cold1", 32'h104, 1'b1, 32'hA1);
        probe("cold2", 32'h108, 1'b1, 32'hA2);
        probe("cold3", 32'h10C, 1'b1, 32'hA3);

        fill("w1", 32'h500, 32'hB0, 0, 0, -1);
        probe("both100", 32'h100, 1'b1, 32'hA0);
        probe("both500", 32'h50C, 1'b1, 32'hB3);
        fill("ev0", 32'h900, 32'h90, 0, 0, -1);
        probe("gone100", 32'h100, 1'b0, 32'h0);
        probe("kept500", 32'h504, 1'b1, 32'hB1);
        fill("ev1", 32'hD00, 32'hD0, 0, 0, -1);
        probe("kept900", 32'h908, 1'b1, 32'h92);
        probe("gone500", 32'h500, 1'b0, 32'h0);
        probe("hitD00", 32'hD0C, 1'b1, 32'hD3);

        fill("stall", 32'h200, 32'hC0, 5, 2, -1);
        probe("stall0", 32'h200, 1'b1, 32'hC0);
        probe("stall1", 32'h204, 1'b1, 32'hC1);
        probe("stall3", 32'h20C, 1'b1, 32'hC3);

        tick();
        cpu_req    = 1'b1;
        cpu_addr   = 32'h300;
        invalidate = 1'b1;
        #1;
        chk("inv_miss_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        tick();
        invalidate = 1'b0;
        cpu_req    = 1'b0;
        chk("inv_wins_mem_req", {31'd0, mem_req}, 32'd0);
        count_busy("idle_flush_len");
        probe("flushed900", 32'h900, 1'b0, 32'h0);
        probe("flushed200", 32'h200, 1'b0, 32'h0);

        fill("pend", 32'h200, 32'hE0, 0, 0, 1);
        cpu_req  = 1'b1;
        cpu_addr = 32'h200;
        #1;
        chk("pend_flush_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        cpu_req = 1'b0;
        count_busy("pend_flush_len");
        probe("pend_gone200", 32'h200, 1'b0, 32'h0);

        tick();
        cpu_req  = 1'b1;
        cpu_addr = 32'h100;
        tick();
        chk("rst_mid_req", {31'd0, mem_req}, 32'd1);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hF0 + i;
            tick();
        end
        reset     = 1'b1;
        mem_rdata = 32'hF2;
        tick();
        chk("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        reset     = 1'b0;
        cpu_req   = 1'b0;
        mem_rdata = 32'hF3;
        tick();
        mem_rvalid = 1'b0;
        chk("late_beat_busy", {31'd0, busy}, 32'd0);
        chk("late_beat_mem_req", {31'd0, mem_req}, 32'd0);
        probe("rst_miss100", 32'h100, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
